// File: rtl/spi_command_decoder.sv
// SPI mode-0 slave that turns host command frames into voice-controller fields and strobes.
// SPI pins are oversampled in the i_clk domain; sclk must run at i_clk/8 or slower.
module spi_command_decoder #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  OP_TUNING   = 8'h01,
    parameter logic [7:0]  OP_NOTE_ON  = 8'h02,
    parameter logic [7:0]  OP_NOTE_OFF = 8'h03
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_spi_sclk,
    input  logic        i_spi_mosi,
    input  logic        i_spi_cs_n,
    output logic [7:0]  o_SPI_voice_index,
    output logic [31:0] o_SPI_tuning_code,
    output logic [6:0]  o_SPI_velocity,
    output logic        o_SPI_note_status,
    output logic        o_SPI_flag_dds,
    output logic        o_SPI_flag_adsr,
    output logic        o_frame_error,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_OPCODE, S_PAYLOAD, S_DRAIN} state_t;

    state_t r_state, w_next_state;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
    logic       r_sclk_prev, r_cs_prev;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic [2:0] r_byte_idx;
    logic [2:0] r_len;
    logic [7:0] r_opcode;
    logic [7:0] r_stage [5];

    logic       w_sclk, w_mosi, w_cs;
    logic       w_sclk_rise, w_cs_fall, w_cs_rise;
    logic       w_sample, w_byte_done;
    logic [7:0] w_byte;
    logic       w_known;
    logic [2:0] w_len;
    logic       w_load_op, w_store, w_commit, w_err;
    logic [7:0] w_frame [5];

    // Synchronizers reset to 0 so a chip select already held low after reset never looks like a fall.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_cs_fall   = ~w_cs & r_cs_prev;
    assign w_cs_rise   = w_cs & ~r_cs_prev;

    // A rise coinciding with the cs_n rise still counts, so a final byte can complete as cs_n lifts.
    assign w_sample    = w_sclk_rise & (~w_cs | w_cs_rise)
                         & ((r_state == S_OPCODE) | (r_state == S_PAYLOAD));
    assign w_byte      = {r_shift[6:0], w_mosi};
    assign w_byte_done = w_sample & (r_bit_cnt == 3'd7);

    always_comb begin
        w_known = 1'b1;
        w_len   = 3'd0;
        if (w_byte == OP_TUNING)        w_len = 3'd5;
        else if (w_byte == OP_NOTE_ON)  w_len = 3'd2;
        else if (w_byte == OP_NOTE_OFF) w_len = 3'd1;
        else                            w_known = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load_op    = 1'b0;
        w_store      = 1'b0;
        w_commit     = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) w_next_state = S_IDLE == S_IDLE ? S_OPCODE : S_IDLE;
            end
            S_OPCODE: begin
                if (w_byte_done && w_known && !w_cs_rise) begin
                    w_load_op    = 1'b1;
                    w_next_state = S_PAYLOAD;
                end else if (w_byte_done && !w_known) begin
                    w_err        = 1'b1;
                    w_next_state = w_cs_rise ? S_IDLE : S_DRAIN;
                end else if (w_cs_rise) begin
                    w_err        = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (w_byte_done && (r_byte_idx == r_len - 3'd1)) begin
                    w_commit     = 1'b1;
                    w_next_state = w_cs_rise ? S_IDLE : S_DRAIN;
                end else if (w_cs_rise) begin
                    w_err        = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_byte_done) begin
                    w_store = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_cs_rise) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_len      <= '0;
            r_opcode   <= '0;
            for (int i = 0; i < 5; i++) r_stage[i] <= '0;
        end else begin
            if (r_state == S_IDLE && w_cs_fall) begin
                r_shift    <= '0;
                r_bit_cnt  <= '0;
                r_byte_idx <= '0;
            end else if (w_sample) begin
                r_shift   <= w_byte;
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_load_op) begin
                r_opcode   <= w_byte;
                r_len      <= w_len;
                r_byte_idx <= '0;
                for (int i = 0; i < 5; i++) r_stage[i] <= '0;
            end else if (w_store) begin
                r_stage[r_byte_idx] <= w_byte;
                r_byte_idx          <= r_byte_idx + 3'd1;
            end
        end
    end

    // Staged payload with the byte completing this cycle merged in at its index.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            w_frame[i] = (r_byte_idx == 3'(i)) ? w_byte : r_stage[i];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_SPI_voice_index <= '0;
            o_SPI_tuning_code <= '0;
            o_SPI_velocity    <= '0;
            o_SPI_note_status <= 1'b0;
            o_SPI_flag_dds    <= 1'b0;
            o_SPI_flag_adsr   <= 1'b0;
            o_frame_error     <= 1'b0;
        end else begin
            o_SPI_flag_dds  <= 1'b0;
            o_SPI_flag_adsr <= 1'b0;
            o_frame_error   <= w_err;
            if (w_commit) begin
                o_SPI_voice_index <= w_frame[0];
                if (r_opcode == OP_TUNING) begin
                    o_SPI_tuning_code <= {w_frame[1], w_frame[2], w_frame[3], w_frame[4]};
                    o_SPI_flag_dds    <= 1'b1;
                end else if (r_opcode == OP_NOTE_ON) begin
                    o_SPI_velocity    <= w_frame[1][6:0];
                    o_SPI_note_status <= |w_frame[1][6:0];
                    o_SPI_flag_adsr   <= 1'b1;
                end else begin
                    o_SPI_note_status <= 1'b0;
                    o_SPI_flag_adsr   <= 1'b1;
                end
            end
        end
    end

    assign o_dbg_state = r_state;

endmodule
